// File: rtl/row_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : row_encoder_arbiter
// Purpose  : Per-source FIFOs drained round-robin into a registered
//            valid/ready port, with source tags and sticky overflow flags.
//            Optional ARB_SRC_HDR_EN: header word before each source change.
// Revision : 1.0  initial release
// ============================================================================
module row_encoder_arbiter #(
    parameter int  NUM_SRC    = 4,
    parameter int  DATA_W     = 16,
    parameter int  FIFO_DEPTH = 4,
    localparam int SRC_W      = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_SRC-1:0]        ovf,
    input  logic                      ovf_clr,
    output logic                      busy
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [NUM_SRC-1:0]        w_empty, w_full, w_pop, w_push, w_drop;
    logic [NUM_SRC*DATA_W-1:0] w_head;
    logic                      w_free, w_found, w_pop_en, w_load_hdr;
    logic [SRC_W-1:0]          w_grant, w_cand, w_pop_idx;
    logic [DATA_W-1:0]         w_pop_data, w_hdr_word;
    int                        w_sum;

    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_data;
    logic [SRC_W-1:0]          r_out_src, r_last;
    logic [NUM_SRC-1:0]        r_ovf;

    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_fifo
            logic [PTR_W-1:0]  r_wptr, r_rptr;
            logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

            assign w_empty[g] = (r_wptr == r_rptr);
            assign w_full[g]  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                                (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
            assign w_pop[g]   = w_pop_en && (w_pop_idx == SRC_W'(g));
            // A full FIFO still accepts a push when it is popped on the same edge.
            assign w_push[g]  = src_ready[g] && (!w_full[g] || w_pop[g]);
            assign w_drop[g]  = src_ready[g] && w_full[g] && !w_pop[g];
            assign w_head[g*DATA_W +: DATA_W] = r_mem[r_rptr[ADDR_W-1:0]];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push[g]) r_wptr <= r_wptr + PTR_W'(1);
                    if (w_pop[g])  r_rptr <= r_rptr + PTR_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[g]) r_mem[r_wptr[ADDR_W-1:0]] <= src_data[g*DATA_W +: DATA_W];
            end
        end
    endgenerate

    // Round-robin search from last+1; descending loop so the nearest candidate wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_cand  = '0;
        w_sum   = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_sum = int'(r_last) + k;
            if (w_sum >= NUM_SRC) w_sum = w_sum - NUM_SRC;
            w_cand = SRC_W'(w_sum);
            if (!w_empty[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
    end

    assign w_free     = !r_out_valid || out_ready;
    assign w_pop_data = w_head[w_pop_idx*DATA_W +: DATA_W];
    assign w_hdr_word = {4'hF, {(DATA_W-4-SRC_W){1'b0}}, w_grant};

`ifdef ARB_SRC_HDR_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_have_prev;
    logic [SRC_W-1:0] r_prev_src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_have_prev <= 1'b0;
            r_prev_src  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop_en) begin
                r_have_prev <= 1'b1;
                r_prev_src  <= w_pop_idx;
            end
        end
    end

    // In HDR the output register holds the header, whose out_src names the FIFO to pop next.
    always_comb begin
        w_state_nxt = r_state;
        w_pop_en    = 1'b0;
        w_pop_idx   = w_grant;
        w_load_hdr  = 1'b0;
        if (w_free) begin
            case (r_state)
                ST_HDR: begin
                    w_pop_en    = 1'b1;
                    w_pop_idx   = r_out_src;
                    w_state_nxt = ST_DATA;
                end
                default: begin
                    if (!w_found) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_have_prev && (w_grant == r_prev_src)) begin
                        w_pop_en    = 1'b1;
                        w_state_nxt = ST_DATA;
                    end else begin
                        w_load_hdr  = 1'b1;
                        w_state_nxt = ST_HDR;
                    end
                end
            endcase
        end
    end
`else
    assign w_pop_en   = w_free && w_found;
    assign w_pop_idx  = w_grant;
    assign w_load_hdr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_last      <= SRC_W'(NUM_SRC - 1);
            r_ovf       <= '0;
        end else begin
            r_ovf <= (ovf_clr ? '0 : r_ovf) | w_drop;
            if (w_free) begin
                if (w_load_hdr) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_hdr_word;
                    r_out_src   <= w_grant;
                end else if (w_pop_en) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_pop_data;
                    r_out_src   <= w_pop_idx;
                    r_last      <= w_pop_idx;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign ovf       = r_ovf;
    assign busy      = (~&w_empty) | r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_row_encoder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_encoder_arbiter
// Purpose  : Self-checking bench for row_encoder_arbiter (default build):
//            vector table, directed corner sequences, queue-based random model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_row_encoder_arbiter;

    localparam int NS    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0]  src_ready = '0;
    logic [DW-1:0]  out_data;
    logic [1:0]     out_src;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [NS-1:0]  ovf;
    logic           ovf_clr = 1'b0;
    logic           busy;

    int total = 0;
    int bad   = 0;

    row_encoder_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .src_data(src_data), .src_ready(src_ready),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready), .ovf(ovf), .ovf_clr(ovf_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per source plus the output register contents.
    logic [DW-1:0] mq [NS][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    int            m_src, m_last;
    logic [NS-1:0] m_ovf;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_valid = 1'b0; m_data = '0; m_src = 0; m_last = NS - 1; m_ovf = '0;
    endtask

    task automatic model_step(input logic [NS-1:0] sr, input logic [NS*DW-1:0] sd,
                              input logic ordy, input logic clr);
        logic [NS-1:0] drop = '0;
        if (!m_valid || ordy) begin
            int pick = -1;
            for (int k = 1; k <= NS; k++) begin
                int s = (m_last + k) % NS;
                if (mq[s].size() > 0) begin pick = s; break; end
            end
            if (pick >= 0) begin
                m_data = mq[pick].pop_front();
                m_src = pick; m_valid = 1'b1; m_last = pick;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int i = 0; i < NS; i++) begin
            if (sr[i]) begin
                if (mq[i].size() >= DEPTH) drop[i] = 1'b1;
                else mq[i].push_back(sd[i*DW +: DW]);
            end
        end
        m_ovf = (clr ? '0 : m_ovf) | drop;
    endtask

    function automatic logic model_busy();
        logic b = m_valid;
        for (int i = 0; i < NS; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk({tag, "_data"}, 64'(out_data), 64'(m_data));
            chk({tag, "_src"}, 64'(out_src), 64'(m_src));
        end
        chk({tag, "_ovf"}, 64'(ovf), 64'(m_ovf));
        chk({tag, "_busy"}, 64'(busy), 64'(model_busy()));
    endtask

    // Apply one cycle of inputs, advance model and DUT, optionally compare.
    task automatic cycle(input logic [NS-1:0] sr, input logic [NS*DW-1:0] sd,
                         input logic ordy, input logic clr, input string tag, input bit do_chk);
        src_ready = sr; src_data = sd; out_ready = ordy; ovf_clr = clr;
        model_step(sr, sd, ordy, clr);
        @(posedge clk);
        #1;
        if (do_chk) check_model(tag);
    endtask

    typedef struct {
        logic [NS-1:0]    sr;
        logic [NS*DW-1:0] sd;
        logic             ordy;
        logic             ev;
        logic [DW-1:0]    ed;
        logic [1:0]       es;
        logic             eb;
    } vec_t;

    vec_t vecs [13];
    localparam logic [63:0] ALL_A = 64'hA003_A002_A001_A000;
    localparam logic [63:0] S2_W  = 64'h0000_1234_0000_0000;

    function automatic vec_t mk(input logic [NS-1:0] sr, input logic [63:0] sd, input logic ev,
                                input logic [DW-1:0] ed, input logic [1:0] es, input logic eb);
        vec_t v;
        v.sr = sr; v.sd = sd; v.ordy = 1'b1; v.ev = ev; v.ed = ed; v.es = es; v.eb = eb;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(4'hF, ALL_A, 1'b0, 16'h0000, 2'd0, 1'b1);
        vecs[1]  = mk(4'h0, '0,    1'b1, 16'hA000, 2'd0, 1'b1);
        vecs[2]  = mk(4'h0, '0,    1'b1, 16'hA001, 2'd1, 1'b1);
        vecs[3]  = mk(4'h0, '0,    1'b1, 16'hA002, 2'd2, 1'b1);
        vecs[4]  = mk(4'hF, ALL_A, 1'b1, 16'hA003, 2'd3, 1'b1);
        vecs[5]  = mk(4'h0, '0,    1'b1, 16'hA000, 2'd0, 1'b1);
        vecs[6]  = mk(4'h0, '0,    1'b1, 16'hA001, 2'd1, 1'b1);
        vecs[7]  = mk(4'h0, '0,    1'b1, 16'hA002, 2'd2, 1'b1);
        vecs[8]  = mk(4'h0, '0,    1'b1, 16'hA003, 2'd3, 1'b1);
        vecs[9]  = mk(4'h0, '0,    1'b0, 16'h0000, 2'd0, 1'b0);
        vecs[10] = mk(4'h4, S2_W,  1'b0, 16'h0000, 2'd0, 1'b1);
        vecs[11] = mk(4'h0, '0,    1'b1, 16'h1234, 2'd2, 1'b1);
        vecs[12] = mk(4'h0, '0,    1'b0, 16'h0000, 2'd0, 1'b0);

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_src", 64'(out_src), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Round-robin bursts then single-source latency
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].sr, vecs[i].sd, vecs[i].ordy, 1'b0, "vec", 1'b0);
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].ed));
                chk($sformatf("vec%0d_src", i), 64'(out_src), 64'(vecs[i].es));
            end
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].eb));
            chk($sformatf("vec%0d_ovf", i), 64'(ovf), 64'd0);
        end

        // Backpressure: source 1 pushes 3 words while out_ready is low for 10 cycles
        for (int i = 0; i < 10; i++)
            cycle((i < 3) ? 4'h2 : 4'h0, {32'h0, 16'hB001 + 16'(i), 16'h0}, 1'b0, 1'b0, "bp", 1'b1);
        chk("bp_hold_data", 64'(out_data), 64'hB001);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        cycle(4'h0, '0, 1'b1, 1'b0, "bp_rel", 1'b1);
        chk("bp_rel_w2", 64'(out_data), 64'hB002);
        cycle(4'h0, '0, 1'b1, 1'b0, "bp_rel", 1'b1);
        chk("bp_rel_w3", 64'(out_data), 64'hB003);
        cycle(4'h0, '0, 1'b1, 1'b0, "bp_rel", 1'b1);
        chk("bp_rel_empty", 64'(out_valid), 64'd0);

        // Overflow on source 3, clear, then drop and clear together
        for (int i = 0; i < 6; i++)
            cycle(4'h8, {16'hC001 + 16'(i), 48'h0}, 1'b0, 1'b0, "ovf", 1'b1);
        chk("ovf_set", 64'(ovf), 64'h8);
        chk("ovf_hold_word1", 64'(out_data), 64'hC001);
        cycle(4'h0, '0, 1'b0, 1'b1, "ovf_clr", 1'b1);
        chk("ovf_cleared", 64'(ovf), 64'h0);
        cycle(4'h8, {16'hC0FF, 48'h0}, 1'b0, 1'b1, "ovf_setclr", 1'b1);
        chk("ovf_set_wins", 64'(ovf), 64'h8);
        for (int i = 0; i < 7; i++) cycle(4'h0, '0, 1'b1, 1'b1, "ovf_drain", 1'b1);
        chk("ovf_drain_idle", 64'(busy), 64'd0);

        // Full FIFO 0 with a same-cycle pop and push
        for (int i = 0; i < 5; i++)
            cycle(4'h1, {48'h0, 16'hD001 + 16'(i)}, 1'b0, 1'b0, "fpp", 1'b1);
        cycle(4'h1, {48'h0, 16'hD006}, 1'b1, 1'b0, "fpp_pp", 1'b1);
        chk("fpp_no_ovf", 64'(ovf), 64'h0);
        chk("fpp_pop_word", 64'(out_data), 64'hD002);
        for (int i = 0; i < 6; i++) cycle(4'h0, '0, 1'b1, 1'b0, "fpp_drain", 1'b1);

        // Asynchronous reset mid-burst with an overflow pending
        for (int i = 0; i < 6; i++)
            cycle(4'h4, {16'h0, 16'hE001 + 16'(i), 32'h0}, 1'b0, 1'b0, "ar", 1'b1);
        chk("ar_pre_ovf", 64'(ovf), 64'h4);
        #3 rst = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_ovf", 64'(ovf), 64'd0);
        #2 rst = 1'b0;
        model_reset();
        cycle(4'hF, 64'hF003_F002_F001_F000, 1'b1, 1'b0, "ar_post", 1'b1);
        cycle(4'h0, '0, 1'b1, 1'b0, "ar_post", 1'b1);
        chk("ar_first_src", 64'(out_src), 64'd0);
        chk("ar_first_data", 64'(out_data), 64'hF000);

        // Randomized traffic; segments vary the downstream acceptance rate
        for (int i = 0; i < 2000; i++) begin
            logic [NS-1:0]    sr;
            logic [NS*DW-1:0] sd;
            int               rate;
            rate = (i / 250) % 4;
            for (int s = 0; s < NS; s++) sr[s] = ($urandom_range(2) == 0);
            sd = {$urandom, $urandom};
            cycle(sr, sd, ($urandom_range(9) < 3 + 2 * rate), ($urandom_range(29) == 0), "rnd", 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
